// File: rtl/muller_c_proj_fv_if.sv
// C-element signal bundle between the io wrapper and the core.
// The master drives the inputs and the slave returns the outputs.
interface muller_c_proj_fv_if;
  logic a;
  logic b;
  logic c;
  logic mode3;
  logic y;
  logic y_n;
  logic agree;
  logic err;

  modport master (
    output a, b, c, mode3,
    input  y, y_n, agree, err
  );

  modport slave (
    input  a, b, c, mode3,
    output y, y_n, agree, err
  );
endinterface

// File: rtl/muller_c_proj_fv.sv
// Muller C-element (2/3-input) with a sticky self-check flag.
// The io wrapper unpacks io_in and instantiates the core as c_element.
module muller_c_core (
  input  logic              clk_i,
  input  logic              rst_i,
  muller_c_proj_fv_if.slave bus
);

  logic y_q;
  logic y_d;
  logic y_prev_q;
  logic agree_q;
  logic err_q;
  logic err_d;
  logic y_n;
  logic all_one;
  logic all_zero;
  logic agree;

  // In 2-input mode c is masked out of both terms.
  always_comb begin
    all_one  = bus.a & bus.b
             & (bus.c | ~bus.mode3);
    all_zero = ~bus.a & ~bus.b
             & (~bus.c | ~bus.mode3);
    agree    = all_one | all_zero;
  end

  always_comb begin
    y_d = y_q;
    unique case (1'b1)
      all_one:  y_d = 1'b1;
      all_zero: y_d = 1'b0;
      default:  y_d = y_q;
    endcase
  end

  assign y_n = ~y_q;

  // y moving after a disagreeing edge, or a broken y_n, latches err.
  always_comb begin
    err_d = err_q;
    if ((y_q != y_prev_q) && !agree_q)
      err_d = 1'b1;
    if (y_n != ~y_q)
      err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      y_q      <= 1'b0;
      y_prev_q <= 1'b0;
      agree_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      y_q      <= y_d;
      y_prev_q <= y_q;
      agree_q  <= agree;
      err_q    <= err_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.y_n   = y_n;
  assign bus.agree = agree;
  assign bus.err   = err_q;

`ifdef FORMAL
  a_no_err: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !err_q
  );

  a_y_needs_agree: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (y_q != $past(y_q)) |-> $past(agree)
  );

  c_y_rise: cover property (
    @(posedge clk_i) disable iff (rst_i)
    $rose(y_q)
  );

  c_y_fall: cover property (
    @(posedge clk_i) disable iff (rst_i)
    $fell(y_q)
  );

  c_y_hold: cover property (
    @(posedge clk_i) disable iff (rst_i)
    !agree ##1 $stable(y_q)
  );
`endif

endmodule

module muller_c_proj_fv (
  input  logic [5:0] io_in,
  output logic [3:0] io_out
);

  logic clk;
  logic rst;

  assign clk = io_in[0];
  assign rst = io_in[1];

  muller_c_proj_fv_if cbus ();

  assign cbus.a     = io_in[2];
  assign cbus.b     = io_in[3];
  assign cbus.c     = io_in[4];
  assign cbus.mode3 = io_in[5];

  muller_c_core c_element (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (cbus)
  );

  assign io_out = {
    cbus.err,
    cbus.agree,
    cbus.y_n,
    cbus.y
  };

endmodule

// File: tb/tb_muller_c_proj_fv.sv
// Directed bench for muller_c_proj_fv.
// io_out packs {err, agree, y_n, y}.
module tb_muller_c_proj_fv;

  logic       clk;
  logic       rst;
  logic [5:0] io_in;
  logic [3:0] io_out;
  int         n_chk;
  int         n_ok;

  muller_c_proj_fv_if stim ();

  assign io_in = {stim.mode3, stim.c, stim.b,
                  stim.a, rst, clk};

  muller_c_proj_fv dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string    tag,
    input logic [3:0] got,
    input logic [3:0] exp
  );
    n_chk++;
    if (got === exp)
      n_ok++;
    else
      $display("FAIL %s got %b exp %b",
               tag, got, exp);
  endtask

  task automatic drive(
    input logic m,
    input logic cc,
    input logic bb,
    input logic aa
  );
    stim.mode3 = m;
    stim.c     = cc;
    stim.b     = bb;
    stim.a     = aa;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_chk = 0;
    n_ok  = 0;
    rst   = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    tick();
    check("reset", io_out, 4'b0110);

    // Reset must win over set-qualifying inputs
    drive(0, 0, 1, 1);
    tick();
    check("rst_hold", io_out, 4'b0110);

    rst = 1'b0;
    #1;
    drive(0, 0, 1, 1);
    check("set_pre", io_out, 4'b0110);
    tick();
    check("set2", io_out, 4'b0101);

    drive(0, 0, 0, 1);
    check("dis_pre", io_out, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dis_hold", io_out, 4'b0001);
    end

    drive(0, 0, 0, 0);
    check("clr_pre", io_out, 4'b0101);
    tick();
    check("clr", io_out, 4'b0110);

    drive(1, 0, 1, 1);
    check("m3_dis", io_out, 4'b0010);
    tick();
    check("m3_hold", io_out, 4'b0010);

    drive(1, 1, 1, 1);
    check("m3_pre", io_out, 4'b0110);
    tick();
    check("m3_set", io_out, 4'b0101);

    drive(1, 1, 0, 1);
    tick();
    check("m3_hold1", io_out, 4'b0001);

    drive(1, 0, 0, 0);
    tick();
    check("m3_clr", io_out, 4'b0110);

    drive(0, 1, 0, 0);
    check("c_ign0", io_out, 4'b0110);
    drive(0, 1, 1, 1);
    tick();
    check("c_ign1", io_out, 4'b0101);

    // mode3 raised with c=0 must hold y on the same edge
    drive(1, 0, 1, 1);
    tick();
    check("mode_sw", io_out, 4'b0001);

    drive(0, 0, 1, 1);
    tick();
    check("pre_rst", io_out, 4'b0101);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst", io_out, 4'b0110);
    tick();
    check("rst_edge", io_out, 4'b0110);

    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rel", io_out, 4'b0110);
    tick();
    check("first_edge", io_out, 4'b0101);

    drive(0, 0, 0, 0);
    tick();
    check("final", io_out, 4'b0110);

    $display("%0d/%0d checks passed",
             n_ok, n_chk);
    $finish;
  end

endmodule
